// File: rtl/uart_tx_fifo.sv
// UART transmitter with a write-side FIFO: runtime frame format and baud divisor,
// queued frames leave back-to-back with no idle gap between stop and next start.
module uart_tx_fifo #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned DIV_WIDTH  = 12
) (
    input  logic                                 clk,
    input  logic                                 rst_l,
    input  logic [DIV_WIDTH-1:0]                 baud_div,
    input  logic [1:0]                           cfg_parity,
    input  logic                                 cfg_stop2,
    input  logic                                 wr_valid,
    input  logic [DATA_WIDTH-1:0]                wr_data,
    output logic                                 wr_ready,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]      fifo_count,
    output logic                                 tx,
    output logic                                 busy,
    output logic                                 frame_done
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned BIT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_e;

    state_e                 state_q, state_d;
    logic [DATA_WIDTH-1:0]  mem_q [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0]  mem_d [FIFO_DEPTH];
    logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]       count_q, count_d;
    logic [DIV_WIDTH-1:0]   baud_cnt_q, baud_cnt_d;
    logic [DIV_WIDTH-1:0]   div_q, div_d;
    logic [BIT_W-1:0]       bit_cnt_q, bit_cnt_d;
    logic [DATA_WIDTH-1:0]  shift_q, shift_d;
    logic                   par_en_q, par_en_d;
    logic                   par_bit_q, par_bit_d;
    logic                   stop2_q, stop2_d;
    logic                   stop_cnt_q, stop_cnt_d;
    logic                   tx_q, tx_d;
    logic                   busy_q, busy_d;
    logic                   frame_done_q, frame_done_d;
    logic                   wr_ready_q, wr_ready_d;

    logic                   push;
    logic                   pop;
    logic                   start;
    logic                   baud_tick;
    logic [DATA_WIDTH-1:0]  head;

    assign baud_tick = (baud_cnt_q == div_q);
    assign head      = mem_q[rd_ptr_q];

    // Next-state, FIFO bookkeeping and registered-output computation
    always_comb begin
        state_d      = state_q;
        mem_d        = mem_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        count_d      = count_q;
        baud_cnt_d   = baud_cnt_q;
        div_d        = div_q;
        bit_cnt_d    = bit_cnt_q;
        shift_d      = shift_q;
        par_en_d     = par_en_q;
        par_bit_d    = par_bit_q;
        stop2_d      = stop2_q;
        stop_cnt_d   = stop_cnt_q;
        tx_d         = tx_q;
        frame_done_d = 1'b0;
        start        = 1'b0;
        pop          = 1'b0;
        push         = wr_valid && wr_ready_q;

        if (state_q != IDLE) begin
            if (baud_tick) begin
                baud_cnt_d = '0;
            end else begin
                baud_cnt_d = baud_cnt_q + DIV_WIDTH'(1);
            end
        end

        case (state_q)
            IDLE: begin
                if (count_q != '0) begin
                    start = 1'b1;
                end
            end
            START: begin
                if (baud_tick) begin
                    state_d   = DATA;
                    bit_cnt_d = '0;
                    tx_d      = shift_q[0];
                    shift_d   = shift_q >> 1;
                end
            end
            DATA: begin
                if (baud_tick) begin
                    if (bit_cnt_q == BIT_W'(DATA_WIDTH - 1)) begin
                        if (par_en_q) begin
                            state_d = PARITY;
                            tx_d    = par_bit_q;
                        end else begin
                            state_d    = STOP;
                            tx_d       = 1'b1;
                            stop_cnt_d = 1'b0;
                        end
                    end else begin
                        bit_cnt_d = bit_cnt_q + BIT_W'(1);
                        tx_d      = shift_q[0];
                        shift_d   = shift_q >> 1;
                    end
                end
            end
            PARITY: begin
                if (baud_tick) begin
                    state_d    = STOP;
                    tx_d       = 1'b1;
                    stop_cnt_d = 1'b0;
                end
            end
            STOP: begin
                if (baud_tick) begin
                    if (stop2_q && !stop_cnt_q) begin
                        stop_cnt_d = 1'b1;
                    end else begin
                        frame_done_d = 1'b1;
                        if (count_q != '0) begin
                            start = 1'b1;
                        end else begin
                            state_d = IDLE;
                            tx_d    = 1'b1;
                        end
                    end
                end
            end
            default: begin
                state_d = IDLE;
                tx_d    = 1'b1;
            end
        endcase

        // Frame start: pop the head and freeze the format for the whole frame
        if (start) begin
            pop        = 1'b1;
            state_d    = START;
            tx_d       = 1'b0;
            baud_cnt_d = '0;
            div_d      = baud_div;
            par_en_d   = (cfg_parity == 2'b01) || (cfg_parity == 2'b10);
            par_bit_d  = (^head) ^ (cfg_parity == 2'b10);
            stop2_d    = cfg_stop2;
            stop_cnt_d = 1'b0;
            shift_d    = head;
        end

        if (push) begin
            mem_d[wr_ptr_q] = wr_data;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        count_d    = count_q + CNT_W'(push) - CNT_W'(pop);
        busy_d     = (state_d != IDLE);
        wr_ready_d = (count_d < CNT_W'(FIFO_DEPTH));
    end

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            state_q      <= IDLE;
            mem_q        <= '{default: '0};
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            baud_cnt_q   <= '0;
            div_q        <= '0;
            bit_cnt_q    <= '0;
            shift_q      <= '0;
            par_en_q     <= 1'b0;
            par_bit_q    <= 1'b0;
            stop2_q      <= 1'b0;
            stop_cnt_q   <= 1'b0;
            tx_q         <= 1'b1;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
            wr_ready_q   <= 1'b1;
        end else begin
            state_q      <= state_d;
            mem_q        <= mem_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            baud_cnt_q   <= baud_cnt_d;
            div_q        <= div_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            par_en_q     <= par_en_d;
            par_bit_q    <= par_bit_d;
            stop2_q      <= stop2_d;
            stop_cnt_q   <= stop_cnt_d;
            tx_q         <= tx_d;
            busy_q       <= busy_d;
            frame_done_q <= frame_done_d;
            wr_ready_q   <= wr_ready_d;
        end
    end

    assign tx         = tx_q;
    assign busy       = busy_q;
    assign frame_done = frame_done_q;
    assign wr_ready   = wr_ready_q;
    assign fifo_count = count_q;

endmodule
